// File: rtl/dcr_if.sv
// Host-side register bus for dcr_bank: write handshake plus registered read port.
interface dcr_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned ADDR_BITS = 8
);
    logic                 host_wr_valid;
    logic                 host_wr_ready;
    logic [ADDR_BITS-1:0] host_addr;
    logic [DATA_BITS-1:0] host_wr_data;
    logic                 host_rd_en;
    logic [DATA_BITS-1:0] host_rd_data;

    modport master (
        output host_wr_valid, host_addr, host_wr_data, host_rd_en,
        input  host_wr_ready, host_rd_data
    );

    modport slave (
        input  host_wr_valid, host_addr, host_wr_data, host_rd_en,
        output host_wr_ready, host_rd_data
    );
endinterface

// File: rtl/dcr_bank.sv
// Device control registers: host-written staging copies, launched atomically into active copies.
// Optional macro DCR_READBACK_EN adds a one-cycle-latency readback of STATUS and staging.
module dcr_bank #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    dcr_if.slave                 host,
    output logic [DATA_BITS-1:0] thread_count [NUM_CORES],
    output logic [DATA_BITS-1:0] start_pc     [NUM_CORES],
    output logic [NUM_CORES-1:0] core_start,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 busy,
    output logic                 kernel_done
);

    typedef enum logic [1:0] {StIdle, StLaunch, StRun, StComplete} state_e;

    state_e               state_q;
    logic [DATA_BITS-1:0] stg_tc_q [NUM_CORES];
    logic [DATA_BITS-1:0] stg_pc_q [NUM_CORES];
    logic [NUM_CORES-1:0] done_mask_q;
    logic                 done_sticky_q;
    logic                 launch_err_q;

    logic [ADDR_BITS-1:0] addr;
    int unsigned          addr_idx;
    logic                 wr_fire;
    logic                 launch_req;
    logic                 clear_req;
    logic [NUM_CORES-1:0] done_next;
    logic [NUM_CORES-1:0] zero_mask;

    // Writes are stalled only during the single LAUNCH cycle so the copy is atomic.
    assign host.host_wr_ready = (state_q != StLaunch);

    always_comb begin
        addr       = host.host_addr;
        addr_idx   = 32'(addr);
        wr_fire    = host.host_wr_valid && (state_q != StLaunch);
        launch_req = wr_fire && (addr_idx == 0) && host.host_wr_data[0];
        clear_req  = wr_fire && (addr_idx == 0) && host.host_wr_data[1];
        done_next  = done_mask_q | core_done;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            zero_mask[i] = (stg_tc_q[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            core_start    <= '0;
            busy          <= 1'b0;
            kernel_done   <= 1'b0;
            done_mask_q   <= '0;
            done_sticky_q <= 1'b0;
            launch_err_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                stg_tc_q[i]     <= '0;
                stg_pc_q[i]     <= '0;
                thread_count[i] <= '0;
                start_pc[i]     <= '0;
            end
        end else begin
            core_start  <= '0;
            kernel_done <= 1'b0;

            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (wr_fire && addr_idx == 2 + 2 * i) stg_tc_q[i] <= host.host_wr_data;
                if (wr_fire && addr_idx == 3 + 2 * i) stg_pc_q[i] <= host.host_wr_data;
            end

            // Clear first so a simultaneous error set takes priority.
            if (clear_req) launch_err_q <= 1'b0;
            if (launch_req && state_q != StIdle) launch_err_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (launch_req) begin
                        state_q       <= StLaunch;
                        busy          <= 1'b1;
                        done_sticky_q <= 1'b0;
                    end
                end
                StLaunch: begin
                    for (int unsigned i = 0; i < NUM_CORES; i++) begin
                        thread_count[i] <= stg_tc_q[i];
                        start_pc[i]     <= stg_pc_q[i];
                    end
                    // Cores with no threads count as already finished.
                    done_mask_q <= zero_mask;
                    core_start  <= ~zero_mask;
                    state_q     <= StRun;
                end
                StRun: begin
                    done_mask_q <= done_next;
                    if (&done_next) begin
                        state_q     <= StComplete;
                        kernel_done <= 1'b1;
                    end
                end
                StComplete: begin
                    done_sticky_q <= 1'b1;
                    busy          <= 1'b0;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DCR_READBACK_EN
    logic [DATA_BITS-1:0] status;
    logic [DATA_BITS-1:0] rd_mux;
    logic [DATA_BITS-1:0] rd_data_q;

    always_comb begin
        status    = '0;
        status[0] = busy;
        status[1] = done_sticky_q;
        status[2] = launch_err_q;
        rd_mux    = '0;
        if (addr_idx == 1) rd_mux = status;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (addr_idx == 2 + 2 * i) rd_mux = stg_tc_q[i];
            if (addr_idx == 3 + 2 * i) rd_mux = stg_pc_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (host.host_rd_en) begin
            rd_data_q <= rd_mux;
        end
    end

    assign host.host_rd_data = rd_data_q;
`else
    logic unused_rd;

    // STATUS bits exist only to be read back; keep them for an identical write-side behaviour.
    assign unused_rd         = ^{host.host_rd_en, done_sticky_q, launch_err_q};
    assign host.host_rd_data = '0;
`endif

endmodule

// File: tb/tb_dcr_bank.sv
// Self-checking bench for dcr_bank: vector table with a scoreboard queue, plus a hand-written
// launch sequence exercising a stalled write and a bounded wait for kernel_done.
module tb_dcr_bank;
    localparam int unsigned NC = 2;
    localparam int unsigned DB = 8;
    localparam int unsigned AB = 8;

    typedef struct {
        logic       rst;
        logic       wv;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       rd;
        logic [1:0] cd;
        logic       b;
        logic       kd;
        logic [1:0] cs;
        logic       rdy;
        logic [7:0] tc0;
        logic [7:0] tc1;
        logic [7:0] pc0;
        logic [7:0] pc1;
        logic [7:0] rdat;
    } vec_t;

    typedef struct {
        int   idx;
        vec_t v;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DB-1:0] thread_count [NC];
    logic [DB-1:0] start_pc     [NC];
    logic [NC-1:0] core_start;
    logic [NC-1:0] core_done;
    logic          busy;
    logic          kernel_done;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];
    exp_t sb[$];

    dcr_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) host ();

    dcr_bank #(
        .NUM_CORES(NC),
        .DATA_BITS(DB),
        .ADDR_BITS(AB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host        (host),
        .thread_count(thread_count),
        .start_pc    (start_pc),
        .core_start  (core_start),
        .core_done   (core_done),
        .busy        (busy),
        .kernel_done (kernel_done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int rst, int wv, int addr, int wd, int rd, int cd,
                                int b, int kd, int cs, int rdy,
                                int tc0, int tc1, int pc0, int pc1, int rdat);
        vec_t v;
        v.rst = 1'(rst);   v.wv  = 1'(wv);   v.addr = 8'(addr); v.wd   = 8'(wd);
        v.rd  = 1'(rd);    v.cd  = 2'(cd);   v.b    = 1'(b);    v.kd   = 1'(kd);
        v.cs  = 2'(cs);    v.rdy = 1'(rdy);  v.tc0  = 8'(tc0);  v.tc1  = 8'(tc1);
        v.pc0 = 8'(pc0);   v.pc1 = 8'(pc1);
`ifdef DCR_READBACK_EN
        v.rdat = 8'(rdat);
`else
        v.rdat = 8'(rdat & 0);
`endif
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic wv, input logic [7:0] addr,
                         input logic [7:0] wd, input logic rd, input logic [1:0] cd);
        reset             = rst;
        host.host_wr_valid = wv;
        host.host_addr     = addr;
        host.host_wr_data  = wd;
        host.host_rd_en    = rd;
        core_done          = cd;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic compare_pop();
        exp_t e;
        e = sb.pop_front();
        chk("busy",        e.idx, 32'(busy),              32'(e.v.b));
        chk("kernel_done", e.idx, 32'(kernel_done),       32'(e.v.kd));
        chk("core_start",  e.idx, 32'(core_start),        32'(e.v.cs));
        chk("wr_ready",    e.idx, 32'(host.host_wr_ready), 32'(e.v.rdy));
        chk("tc0",         e.idx, 32'(thread_count[0]),   32'(e.v.tc0));
        chk("tc1",         e.idx, 32'(thread_count[1]),   32'(e.v.tc1));
        chk("pc0",         e.idx, 32'(start_pc[0]),       32'(e.v.pc0));
        chk("pc1",         e.idx, 32'(start_pc[1]),       32'(e.v.pc1));
        chk("rd_data",     e.idx, 32'(host.host_rd_data), 32'(e.v.rdat));
    endtask

    initial begin
        int   cyc;
        logic seen;
        logic [7:0] exp_rd;

        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2'b00);

        //            rst wv ad  wd  rd cd   b kd cs rdy tc0 tc1 pc0    pc1    rdat
        vecs.push_back(mk(1, 0, 0, 0,    0, 0,  0, 0, 0, 1,  0, 0, 0,     0,     0));
        vecs.push_back(mk(0, 1, 2, 4,    0, 0,  0, 0, 0, 1,  0, 0, 0,     0,     0));
        vecs.push_back(mk(0, 1, 3, 'h10, 0, 0,  0, 0, 0, 1,  0, 0, 0,     0,     0));
        vecs.push_back(mk(0, 1, 4, 8,    0, 0,  0, 0, 0, 1,  0, 0, 0,     0,     0));
        vecs.push_back(mk(0, 1, 5, 'h20, 0, 0,  0, 0, 0, 1,  0, 0, 0,     0,     0));
        vecs.push_back(mk(0, 1, 0, 1,    0, 0,  1, 0, 0, 0,  0, 0, 0,     0,     0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  1, 0, 3, 1,  4, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 1, 2, 9,    0, 0,  1, 0, 0, 1,  4, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 1,  1, 0, 0, 1,  4, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  1, 0, 0, 1,  4, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 2,  1, 1, 0, 1,  4, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  0, 0, 0, 1,  4, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 1, 0, 1,    0, 0,  1, 0, 0, 0,  4, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  1, 0, 3, 1,  9, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 3,  1, 1, 0, 1,  9, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  0, 0, 0, 1,  9, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 1, 2, 0,    0, 0,  0, 0, 0, 1,  9, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 1, 4, 5,    0, 0,  0, 0, 0, 1,  9, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 1, 0, 1,    0, 0,  1, 0, 0, 0,  9, 8, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  1, 0, 2, 1,  0, 5, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 1,  1, 0, 0, 1,  0, 5, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 2,  1, 1, 0, 1,  0, 5, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  0, 0, 0, 1,  0, 5, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 1, 4, 0,    0, 0,  0, 0, 0, 1,  0, 5, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 1, 0, 1,    0, 0,  1, 0, 0, 0,  0, 5, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  1, 0, 0, 1,  0, 0, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  1, 1, 0, 1,  0, 0, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  0, 0, 0, 1,  0, 0, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 1, 2, 3,    0, 0,  0, 0, 0, 1,  0, 0, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 1, 0, 1,    0, 0,  1, 0, 0, 0,  0, 0, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  1, 0, 1, 1,  3, 0, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 1, 0, 3,    0, 0,  1, 0, 0, 1,  3, 0, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 1, 0,    1, 0,  1, 0, 0, 1,  3, 0, 'h10,  'h20,  'h05));
        vecs.push_back(mk(0, 0, 0, 0,    0, 1,  1, 1, 0, 1,  3, 0, 'h10,  'h20,  'h05));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  0, 0, 0, 1,  3, 0, 'h10,  'h20,  'h05));
        vecs.push_back(mk(0, 0, 1, 0,    1, 0,  0, 0, 0, 1,  3, 0, 'h10,  'h20,  'h06));
        vecs.push_back(mk(0, 1, 0, 2,    0, 0,  0, 0, 0, 1,  3, 0, 'h10,  'h20,  'h06));
        vecs.push_back(mk(0, 0, 1, 0,    1, 0,  0, 0, 0, 1,  3, 0, 'h10,  'h20,  'h02));
        vecs.push_back(mk(0, 1, 3, 'hA5, 0, 0,  0, 0, 0, 1,  3, 0, 'h10,  'h20,  'h02));
        vecs.push_back(mk(0, 0, 3, 0,    1, 0,  0, 0, 0, 1,  3, 0, 'h10,  'h20,  'hA5));
        vecs.push_back(mk(0, 0, 0, 0,    1, 0,  0, 0, 0, 1,  3, 0, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 2, 0,    1, 0,  0, 0, 0, 1,  3, 0, 'h10,  'h20,  'h03));
        vecs.push_back(mk(0, 0, 7, 0,    1, 0,  0, 0, 0, 1,  3, 0, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 1, 0, 1,    0, 0,  1, 0, 0, 0,  3, 0, 'h10,  'h20,  0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  1, 0, 1, 1,  3, 0, 'hA5,  'h20,  0));
        vecs.push_back(mk(1, 0, 0, 0,    0, 0,  0, 0, 0, 1,  0, 0, 0,     0,     0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 1,  0, 0, 0, 1,  0, 0, 0,     0,     0));
        vecs.push_back(mk(0, 1, 2, 2,    0, 0,  0, 0, 0, 1,  0, 0, 0,     0,     0));
        vecs.push_back(mk(0, 1, 3, 'h33, 0, 0,  0, 0, 0, 1,  0, 0, 0,     0,     0));
        vecs.push_back(mk(0, 1, 0, 1,    0, 0,  1, 0, 0, 0,  0, 0, 0,     0,     0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  1, 0, 1, 1,  2, 0, 'h33,  0,     0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 1,  1, 1, 0, 1,  2, 0, 'h33,  0,     0));
        vecs.push_back(mk(0, 0, 0, 0,    0, 0,  0, 0, 0, 1,  2, 0, 'h33,  0,     0));

        for (int k = 0; k < vecs.size(); k++) begin
            exp_t e;
            @(negedge clk);
            if (sb.size() > 0) compare_pop();
            drive(vecs[k].rst, vecs[k].wv, vecs[k].addr, vecs[k].wd, vecs[k].rd, vecs[k].cd);
            e.idx = k;
            e.v   = vecs[k];
            sb.push_back(e);
        end
        @(negedge clk);
        if (sb.size() > 0) compare_pop();

        // Launch, then try to overwrite staging during the stalled LAUNCH cycle.
        drive(1'b0, 1'b1, 8'd2, 8'd7, 1'b0, 2'b00);
        tick();
        drive(1'b0, 1'b1, 8'd0, 8'd1, 1'b0, 2'b00);
        tick();
        chk("launch_ready", 100, 32'(host.host_wr_ready), 32'd0);
        chk("launch_busy",  100, 32'(busy),               32'd1);
        drive(1'b0, 1'b1, 8'd2, 8'h55, 1'b0, 2'b00);
        tick();
        chk("run_tc0",   101, 32'(thread_count[0]), 32'd7);
        chk("run_start", 101, 32'(core_start),      32'd1);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 2'b01);
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            tick();
            if (kernel_done) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        chk("kdone_seen",    102, 32'(seen), 32'd1);
        chk("kdone_latency", 102, 32'(cyc),  32'd1);
        drive(1'b0, 1'b0, 8'd2, 8'd0, 1'b1, 2'b00);
        tick();
        chk("idle_busy", 103, 32'(busy), 32'd0);
`ifdef DCR_READBACK_EN
        exp_rd = 8'd7;
`else
        exp_rd = 8'd0;
`endif
        chk("stalled_write_dropped", 103, 32'(host.host_rd_data), 32'(exp_rd));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcr_bank.md
DCR_BANK -- requirements
Module: dcr_bank

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of cores configured.
REQ-002 SHALL have parameter DATA_BITS, default 8, width of thread_count, start_pc and host data.
REQ-003 SHALL have parameter ADDR_BITS, default 8, host address width.
REQ-004 SHALL have ports: clk input 1 clock; reset input 1 synchronous, active-high.
REQ-005 SHALL have ports: host_wr_valid input 1; host_wr_ready output 1; host_addr input ADDR_BITS; host_wr_data input DATA_BITS.
REQ-006 SHALL have ports: host_rd_en input 1; host_rd_data output DATA_BITS, the read result.
REQ-007 SHALL have ports: thread_count output DATA_BITS x NUM_CORES (unpacked); start_pc output DATA_BITS x NUM_CORES (unpacked); both are active copies.
REQ-008 SHALL have ports: core_start output NUM_CORES, start pulse; core_done input NUM_CORES, level or pulse; busy output 1; kernel_done output 1, pulse.

Function
REQ-009 Address map SHALL be: 0 CTRL (write-only: bit0 launch, bit1 clear_err); 1 STATUS (read-only: bit0 busy, bit1 done_sticky, bit2 launch_err); 2+2i staging thread_count[i]; 3+2i staging start_pc[i].
REQ-010 A write SHALL occur when host_wr_valid and host_wr_ready are both high; writes to STATUS or to addresses at or above 2+2*NUM_CORES SHALL be ignored.
REQ-011 Staging registers SHALL be writable in every state; they SHALL affect only the next launch.
REQ-012 FSM states SHALL be IDLE, LAUNCH, RUN and COMPLETE.
REQ-013 In IDLE, a CTRL write with bit0=1 SHALL move the FSM to LAUNCH and clear done_sticky.
REQ-014 In LAUNCH (one cycle), all staging registers SHALL be copied atomically to thread_count/start_pc.
REQ-015 In LAUNCH, host_wr_ready SHALL be 0; it SHALL be 1 in every other state.
REQ-016 In LAUNCH, done_mask[i] SHALL be preset to 1 where staging thread_count[i]==0, and to 0 otherwise.
REQ-017 core_start[i] SHALL pulse for exactly one cycle, the cycle after LAUNCH, and only for cores with nonzero thread_count; the FSM SHALL enter RUN in that same cycle.
REQ-018 In RUN, done_mask[i] SHALL be set when core_done[i] is high, and SHALL remain set until the next launch.
REQ-019 In RUN, when done_mask is all ones the FSM SHALL move to COMPLETE; with all counts zero this SHALL happen in the first RUN cycle.
REQ-020 core_done SHALL be ignored outside RUN.
REQ-021 COMPLETE SHALL last one cycle, assert kernel_done for that cycle, set done_sticky, and return to IDLE.
REQ-022 busy SHALL be 1 in LAUNCH, RUN and COMPLETE, and 0 in IDLE.
REQ-023 A launch write outside IDLE SHALL be ignored and SHALL set launch_err.
REQ-024 A CTRL write with bit1=1 SHALL clear launch_err; if the same write also sets launch_err, the set SHALL win.
REQ-025 Active thread_count/start_pc SHALL change only in LAUNCH.
REQ-026 Data narrower than DATA_BITS SHALL be zero-extended; STATUS SHALL be zero-extended to DATA_BITS.

Reset
REQ-027 On reset, all staging, active, done_mask and sticky bits SHALL clear to 0.
REQ-028 On reset, the FSM SHALL go to IDLE; core_start, busy, kernel_done and host_rd_data SHALL be 0; host_wr_ready SHALL be 1 the cycle after reset.
REQ-029 Reset asserted in any state, including mid-RUN, SHALL abort the kernel with no kernel_done pulse.

Configuration
REQ-030 Macro DCR_READBACK_EN defined: host_rd_en SHALL return the STATUS or staging register at host_addr on host_rd_data with one-cycle latency; out-of-range addresses and CTRL SHALL read 0; host_rd_data SHALL hold its value when host_rd_en is low.
REQ-031 Macro DCR_READBACK_EN undefined: host_rd_data SHALL be constant 0 and host_rd_en SHALL be ignored; all other behaviour SHALL be unchanged.

Verification
REQ-032 Launch/complete: NUM_CORES=2, write addr2=4, addr3=0x10, addr4=8, addr5=0x20, then CTRL=1 -> thread_count={4,8} and start_pc={0x10,0x20} after LAUNCH; core_start=2'b11 for 1 cycle; core_done[0] then core_done[1] -> kernel_done single pulse one cycle after the last done; busy falls with it.
REQ-033 Zero-thread core: addr2=0, addr4=5, launch -> core_start=2'b10; core_done[1] alone -> kernel_done; all counts zero -> kernel_done 3 cycles after the CTRL write, with no core_start.
REQ-034 Launch while busy: CTRL=1 during RUN -> FSM unaffected; STATUS reads 0x05 (busy, launch_err); CTRL=2 after completion -> STATUS reads 0x02.
REQ-035 Staging isolation: write addr2=9 during RUN -> thread_count[0] unchanged until the next launch, then 9; host_wr_ready=0 exactly during the LAUNCH cycle.
REQ-036 Reset mid-RUN: assert reset with one core outstanding -> next cycle busy=0, outputs 0, no kernel_done; then a fresh launch works.
REQ-037 Readback: with DCR_READBACK_EN, write addr3=0xA5, then rd_en at addr3 -> host_rd_data=0xA5 the next cycle; without DCR_READBACK_EN -> 0.
